alu_op_sequencer: RTL and testbench

//  Upstream control/operand stage for the 16-bit 2-op ALU (sel: 00 ADD, 01 SUB, 10 AND, 11 OR).
//  - Accepts one 16-bit instruction via valid/ready.
//  - Reads operands from an 8x16 register file and drives the ALU a/b/sel inputs from registers.
//  - Captures the ALU result and zero flag, writes back, then signals completion.
//  - Multi-cycle, non-pipelined: one instruction every 4 cycles.

---
 rtl/alu_pkg.sv | 61 ++++++
 rtl/alu_regfile.sv | 48 ++++
 rtl/alu_op_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: op codes, FSM states,
// register-file geometry and the instruction word layout.
package alu_pkg;

    // ALU operation select encoding
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    // Sequencer FSM states; one instruction walks through all four
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } seq_state_e;

    localparam int INSTR_W     = 16;
    localparam int NUM_REGS    = 8;
    localparam int REG_ADDR_W  = 3;
    localparam int IMM_FIELD_W = 4;

    // Instruction field bit positions
    localparam int OP_MSB     = 15;
    localparam int OP_LSB     = 14;
    localparam int RD_MSB     = 13;
    localparam int RD_LSB     = 11;
    localparam int RS_MSB     = 10;
    localparam int RS_LSB     = 8;
    localparam int RT_MSB     = 7;
    localparam int RT_LSB     = 5;
    localparam int IMM_EN_BIT = 4;
    localparam int IMM_MSB    = 3;
    localparam int IMM_LSB    = 0;

    // Packed view of the instruction word; member order matches the bit positions above
    typedef struct packed {
        alu_op_e                 op;
        logic [REG_ADDR_W-1:0]   rd;
        logic [REG_ADDR_W-1:0]   rs;
        logic [REG_ADDR_W-1:0]   rt;
        logic                    imm_en;
        logic [IMM_FIELD_W-1:0]  imm;
    } instr_t;

    // Split a raw instruction word into its fields using the explicit positions
    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] word);
        instr_t d;
        d.op     = alu_op_e'(word[OP_MSB:OP_LSB]);
        d.rd     = word[RD_MSB:RD_LSB];
        d.rs     = word[RS_MSB:RS_LSB];
        d.rt     = word[RT_MSB:RT_LSB];
        d.imm_en = word[IMM_EN_BIT];
        d.imm    = word[IMM_MSB:IMM_LSB];
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8-entry register file: R0 reads as zero and ignores writes, R1..R7 are
// async-reset flops. Three combinational read ports and one write port.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    output logic [DATA_W-1:0]     dbg_data
);

    // Read-side view of every entry; index 0 is a constant zero
    logic [DATA_W-1:0] entry_view [NUM_REGS];

    assign entry_view[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;

            // Storage word: cleared on reset, written only when addressed
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (wr_en && (wr_addr == REG_ADDR_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign entry_view[gi] = entry_reg;
        end
    endgenerate

    assign rs_data  = entry_view[rs_addr];
    assign rt_data  = entry_view[rt_addr];
    assign dbg_data = entry_view[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Control/operand stage for a 16-bit two-operand ALU. Accepts one
// instruction, reads operands, drives the ALU from registers, captures the
// result and writes it back. Fixed four-cycle, non-pipelined flow.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 4    // must not exceed the 4-bit immediate field
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  ld_en,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [1:0]            alu_sel,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_zero,
    output logic                  done,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  zero_flag,
    output logic                  busy,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    seq_state_e        state_reg;
    instr_t            instr_reg;
    logic [DATA_W-1:0] alu_a_reg;
    logic [DATA_W-1:0] alu_b_reg;
    alu_op_e           alu_sel_reg;
    logic              done_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic              zero_flag_reg;

    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm_ext;
    logic [DATA_W-1:0]     operand_b_next;
    logic                  wr_en_next;
    logic [REG_ADDR_W-1:0] wr_addr_next;
    logic [DATA_W-1:0]     wr_data_next;
    logic                  accept;

    // Preload has priority over new instructions, so ready drops while ld_en is high
    assign instr_ready = (state_reg == ST_IDLE) && !ld_en;
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state_reg != ST_IDLE);

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_sel   = alu_sel_reg;
    assign done      = done_reg;
    assign wb_data   = wb_data_reg;
    assign zero_flag = zero_flag_reg;

    // Immediate is unsigned: zero-extend the low IMM_W bits to the datapath width
    assign imm_ext        = DATA_W'(instr_reg.imm[IMM_W-1:0]);
    assign operand_b_next = instr_reg.imm_en ? imm_ext : rt_data;

    // Single write port: preload only in IDLE, writeback only in EXEC, so they never collide
    always_comb begin
        wr_en_next   = 1'b0;
        wr_addr_next = ld_addr;
        wr_data_next = ld_data;
        if ((state_reg == ST_IDLE) && ld_en) begin
            wr_en_next = 1'b1;
        end else if (state_reg == ST_EXEC) begin
            wr_en_next   = 1'b1;
            wr_addr_next = instr_reg.rd;
            wr_data_next = alu_result;
        end
    end

    alu_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en_next),
        .wr_addr  (wr_addr_next),
        .wr_data  (wr_data_next),
        .rs_addr  (instr_reg.rs),
        .rt_addr  (instr_reg.rt),
        .dbg_addr (dbg_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .dbg_data (dbg_data)
    );

    // Sequencer FSM with registered ALU drive, result capture and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            instr_reg     <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_sel_reg   <= OP_ADD;
            done_reg      <= 1'b0;
            wb_data_reg   <= '0;
            zero_flag_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        instr_reg <= decode_instr(instr);
                        state_reg <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Operands are latched here, so rd==rs/rt later sees the old values
                    alu_a_reg   <= rs_data;
                    alu_b_reg   <= operand_b_next;
                    alu_sel_reg <= instr_reg.op;
                    state_reg   <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Capture even when rd==0; only the regfile discards the write
                    wb_data_reg   <= alu_result;
                    zero_flag_reg <= alu_zero;
                    done_reg      <= 1'b1;
                    state_reg     <= ST_WB;
                end
                ST_WB: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: sequencer plus a behavioural ALU, one task per scenario.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_sel;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        done;
    logic [15:0] wb_data;
    logic        zero_flag;
    logic        busy;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    alu_op_sequencer #(.DATA_W(16), .IMM_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .done        (done),
        .wb_data     (wb_data),
        .zero_flag   (zero_flag),
        .busy        (busy),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Behavioural 2-op ALU the sequencer drives
    always_comb begin
        alu_result = '0;
        case (alu_sel)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end
    assign alu_zero = (alu_result == 16'h0000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mk(input logic [1:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt,
                                       input logic ie, input logic [3:0] imm);
        return {op, rd, rs, rt, ie, imm};
    endfunction

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL wait_idle busy got=%b exp=0", busy); end
    endtask

    // Issue one instruction; lat = edges from the accept edge until done is seen
    task automatic run_instr(input logic [15:0] w, output int lat);
        int n = 0;
        @(negedge clk);
        instr = w; instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (instr_ready !== 1'b1) begin failures++; $display("FAIL issue_ready got=%b exp=1", instr_ready); end
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin @(negedge clk); lat++; end
        $display("txn instr=%h lat=%0d wb_data=%h zero_flag=%b", w, lat, wb_data, zero_flag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; ld_en = 1'b0;
        ld_addr = '0; ld_data = '0; dbg_addr = '0;
        repeat (3) @(negedge clk);
        checks++; if (alu_a !== 16'h0) begin failures++; $display("FAIL rst_alu_a got=%h exp=0000", alu_a); end
        checks++; if (alu_b !== 16'h0) begin failures++; $display("FAIL rst_alu_b got=%h exp=0000", alu_b); end
        checks++; if (alu_sel !== 2'b00) begin failures++; $display("FAIL rst_alu_sel got=%b exp=00", alu_sel); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (wb_data !== 16'h0) begin failures++; $display("FAIL rst_wb_data got=%h exp=0000", wb_data); end
        checks++; if (zero_flag !== 1'b0) begin failures++; $display("FAIL rst_zero_flag got=%b exp=0", zero_flag); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", instr_ready); end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            checks++;
            if (dbg_data !== 16'h0) begin failures++; $display("FAIL rst_reg%0d got=%h exp=0000", i, dbg_data); end
        end
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_add();
        int lat;
        load(3'd1, 16'h0003);
        load(3'd2, 16'h0005);
        run_instr(mk(2'b00, 3'd3, 3'd1, 3'd2, 1'b0, 4'h0), lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
        checks++; if (wb_data !== 16'h0008) begin failures++; $display("FAIL add_wb got=%h exp=0008", wb_data); end
        checks++; if (zero_flag !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", zero_flag); end
        checks++; if (alu_a !== 16'h0003) begin failures++; $display("FAIL add_alu_a got=%h exp=0003", alu_a); end
        checks++; if (alu_b !== 16'h0005) begin failures++; $display("FAIL add_alu_b got=%h exp=0005", alu_b); end
        checks++; if (alu_sel !== 2'b00) begin failures++; $display("FAIL add_alu_sel got=%b exp=00", alu_sel); end
        dbg_addr = 3'd3; #1;
        checks++; if (dbg_data !== 16'h0008) begin failures++; $display("FAIL add_r3 got=%h exp=0008", dbg_data); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_sub();
        int lat;
        run_instr(mk(2'b01, 3'd4, 3'd1, 3'd1, 1'b0, 4'h0), lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL subz_latency got=%0d exp=2", lat); end
        checks++; if (wb_data !== 16'h0000) begin failures++; $display("FAIL subz_wb got=%h exp=0000", wb_data); end
        checks++; if (zero_flag !== 1'b1) begin failures++; $display("FAIL subz_zero got=%b exp=1", zero_flag); end
        load(3'd5, 16'h0000);
        load(3'd6, 16'h0001);
        run_instr(mk(2'b01, 3'd7, 3'd5, 3'd6, 1'b0, 4'h0), lat);
        checks++; if (wb_data !== 16'hFFFF) begin failures++; $display("FAIL subw_wb got=%h exp=ffff", wb_data); end
        checks++; if (zero_flag !== 1'b0) begin failures++; $display("FAIL subw_zero got=%b exp=0", zero_flag); end
        dbg_addr = 3'd7; #1;
        checks++; if (dbg_data !== 16'hFFFF) begin failures++; $display("FAIL subw_r7 got=%h exp=ffff", dbg_data); end
    endtask

    task automatic test_imm_r0();
        int lat;
        run_instr(mk(2'b11, 3'd0, 3'd2, 3'd0, 1'b1, 4'hA), lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL or_latency got=%0d exp=2", lat); end
        checks++; if (wb_data !== 16'h000F) begin failures++; $display("FAIL or_wb got=%h exp=000f", wb_data); end
        dbg_addr = 3'd0; #1;
        checks++; if (dbg_data !== 16'h0000) begin failures++; $display("FAIL or_r0 got=%h exp=0000", dbg_data); end
        // AND with immediate: 0xFFFF & 0xC
        run_instr(mk(2'b10, 3'd2, 3'd7, 3'd0, 1'b1, 4'hC), lat);
        checks++; if (wb_data !== 16'h000C) begin failures++; $display("FAIL and_wb got=%h exp=000c", wb_data); end
        checks++; if (alu_b !== 16'h000C) begin failures++; $display("FAIL and_alu_b got=%h exp=000c", alu_b); end
        // rd==rs==rt: old R1 (3) is used for both operands
        run_instr(mk(2'b00, 3'd1, 3'd1, 3'd1, 1'b0, 4'h0), lat);
        checks++; if (wb_data !== 16'h0006) begin failures++; $display("FAIL self_wb got=%h exp=0006", wb_data); end
        dbg_addr = 3'd1; #1;
        checks++; if (dbg_data !== 16'h0006) begin failures++; $display("FAIL self_r1 got=%h exp=0006", dbg_data); end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int dcount = 0;
        wait_idle();
        instr = mk(2'b00, 3'd0, 3'd1, 3'd1, 1'b0, 4'h0);
        instr_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (instr_ready) acc.push_back(c);
            if (done) dcount++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        $display("txn back_to_back accepts=%0d dones=%0d", acc.size(), dcount);
        checks++; if (acc.size() !== 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", acc.size()); end
        checks++; if (dcount !== 4) begin failures++; $display("FAIL b2b_dones got=%0d exp=4", dcount); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] !== 4) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", acc[i] - acc[i-1]); end
        end
        checks++; if (wb_data !== 16'h000C) begin failures++; $display("FAIL b2b_wb got=%h exp=000c", wb_data); end
    endtask

    task automatic test_ld_in_exec();
        wait_idle();
        instr = mk(2'b00, 3'd5, 3'd6, 3'd0, 1'b0, 4'h0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ldx_busy got=%b exp=1", busy); end
        ld_en = 1'b1; ld_addr = 3'd6; ld_data = 16'h1234;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ldx_done got=%b exp=1", done); end
        checks++; if (wb_data !== 16'h0001) begin failures++; $display("FAIL ldx_wb got=%h exp=0001", wb_data); end
        @(negedge clk);
        ld_en = 1'b0;
        dbg_addr = 3'd6; #1;
        checks++; if (dbg_data !== 16'h0001) begin failures++; $display("FAIL ldx_r6 got=%h exp=0001", dbg_data); end
        dbg_addr = 3'd5; #1;
        checks++; if (dbg_data !== 16'h0001) begin failures++; $display("FAIL ldx_r5 got=%h exp=0001", dbg_data); end
        $display("txn load_during_exec r5=%h", dbg_data);
    endtask

    task automatic test_ld_priority();
        int dcount = 0;
        wait_idle();
        ld_en = 1'b1; ld_addr = 3'd4; ld_data = 16'h00AA;
        instr = mk(2'b00, 3'd3, 3'd7, 3'd7, 1'b0, 4'h0);
        instr_valid = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL ldp_ready got=%b exp=0", instr_ready); end
        @(negedge clk);
        ld_en = 1'b0; instr_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ldp_busy got=%b exp=0", busy); end
        dbg_addr = 3'd4; #1;
        checks++; if (dbg_data !== 16'h00AA) begin failures++; $display("FAIL ldp_r4 got=%h exp=00aa", dbg_data); end
        repeat (4) begin @(negedge clk); if (done) dcount++; end
        checks++; if (dcount !== 0) begin failures++; $display("FAIL ldp_no_done got=%0d exp=0", dcount); end
        dbg_addr = 3'd3; #1;
        checks++; if (dbg_data !== 16'h0008) begin failures++; $display("FAIL ldp_r3 got=%h exp=0008", dbg_data); end
        $display("txn load_priority r4=00aa");
    endtask

    task automatic test_reset_mid_op();
        wait_idle();
        instr = mk(2'b00, 3'd6, 3'd4, 3'd4, 1'b0, 4'h0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmo_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmo_busy got=%b exp=0", busy); end
        checks++; if (alu_a !== 16'h0) begin failures++; $display("FAIL rmo_alu_a got=%h exp=0000", alu_a); end
        dbg_addr = 3'd6; #1;
        checks++; if (dbg_data !== 16'h0) begin failures++; $display("FAIL rmo_r6 got=%h exp=0000", dbg_data); end
        dbg_addr = 3'd4; #1;
        checks++; if (dbg_data !== 16'h0) begin failures++; $display("FAIL rmo_r4 got=%h exp=0000", dbg_data); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rmo_done got=%b exp=0", done); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rmo_done_after got=%b exp=0", done); end
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rmo_ready got=%b exp=1", instr_ready); end
        checks++; if (wb_data !== 16'h0) begin failures++; $display("FAIL rmo_wb got=%h exp=0000", wb_data); end
        $display("txn reset_mid_op");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_imm_r0();
        test_back_to_back();
        test_ld_in_exec();
        test_ld_priority();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
